// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for one output tile of the 8x8 weight-stationary MAC core.
// Optional stall counter output is built when CORE_SEQ_PERF_EN is defined.
module core_seq_ctrl #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int ADDR_W  = 11,
    parameter int MAX_ACT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic [6:0]        n_act,
    input  logic              acc_mode,
    input  logic              ofifo_valid,
    output logic [63:0]       inst,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_W_L0      = 4'd1,
        S_W_LOAD    = 4'd2,
        S_LOAD_WAIT = 4'd3,
        S_X_L0      = 4'd4,
        S_EXEC      = 4'd5,
        S_DRAIN_RD  = 4'd6,
        S_DRAIN_WR  = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    // SRAM chip/write enables are active-low, so the quiet word holds them high.
    localparam logic [63:0] IDLE_WORD = 64'h0000_0001_800C_0000;
    localparam logic [6:0]  ROW_C     = 7'(ROW);
    localparam logic [6:0]  WAIT_LAST = 7'(ROW + COL - 1);
    localparam logic [6:0]  MAX_C     = 7'(MAX_ACT);

    state_t              state_q, state_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   w_q, w_d, x_q, x_d, p_q, p_d;
    logic [6:0]          n_q, n_d;
    logic                acc_q, acc_d;
    logic [63:0]         inst_q, inst_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;

    // State, command latches and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            w_q     <= '0;
            x_q     <= '0;
            p_q     <= '0;
            n_q     <= 7'd0;
            acc_q   <= 1'b0;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            x_q     <= x_d;
            p_q     <= p_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state and the instruction word the current state asks for.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        x_d     = x_q;
        p_d     = p_q;
        n_d     = n_q;
        acc_d   = acc_q;
        inst_d  = IDLE_WORD;
        busy_d  = (state_q != S_IDLE);
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_act > MAX_C) begin
                        err_d = 1'b1;
                    end else if (n_act == 7'd0) begin
                        done_d = 1'b1;
                    end else begin
                        w_d     = w_base;
                        x_d     = x_base;
                        p_d     = p_base;
                        n_d     = n_act;
                        acc_d   = acc_mode;
                        cnt_d   = 7'd0;
                        state_d = S_W_L0;
                    end
                end else begin
                    cnt_d = 7'd0;
                end
            end
            S_W_L0: begin
                if (cnt_q < ROW_C) begin
                    inst_d[19]          = 1'b0;
                    inst_d[7 +: ADDR_W] = w_q + ADDR_W'(cnt_q);
                end else begin
                    inst_d[19] = 1'b1;
                end
                // l0_wr trails the read by one cycle for the SRAM latency.
                inst_d[2] = (cnt_q != 7'd0);
                if (cnt_q == ROW_C) begin
                    cnt_d   = 7'd0;
                    state_d = S_W_LOAD;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_W_LOAD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
                if (cnt_q == ROW_C - 7'd1) begin
                    cnt_d   = 7'd0;
                    state_d = S_LOAD_WAIT;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_LOAD_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 7'd0;
                    state_d = S_X_L0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_X_L0: begin
                if (cnt_q < n_q) begin
                    inst_d[19]          = 1'b0;
                    inst_d[7 +: ADDR_W] = x_q + ADDR_W'(cnt_q);
                end else begin
                    inst_d[19] = 1'b1;
                end
                inst_d[2] = (cnt_q != 7'd0);
                if (cnt_q == n_q) begin
                    cnt_d   = 7'd0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
                if (cnt_q == n_q - 7'd1) begin
                    cnt_d   = 7'd0;
                    state_d = S_DRAIN_RD;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_DRAIN_RD: begin
                if (ofifo_valid) begin
                    inst_d[35]           = 1'b1;
                    inst_d[32]           = 1'b0;
                    inst_d[20 +: ADDR_W] = p_q + ADDR_W'(cnt_q);
                    state_d              = S_DRAIN_WR;
                end else begin
                    state_d = S_DRAIN_RD;
                end
            end
            S_DRAIN_WR: begin
                inst_d[6]            = 1'b1;
                inst_d[32]           = 1'b0;
                inst_d[31]           = 1'b0;
                inst_d[33]           = acc_q;
                inst_d[34]           = ~acc_q;
                inst_d[20 +: ADDR_W] = p_q + ADDR_W'(cnt_q);
                if (cnt_q == n_q - 7'd1) begin
                    cnt_d   = 7'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 7'd1;
                    state_d = S_DRAIN_RD;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 7'd0;
            end
        endcase
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

`ifdef CORE_SEQ_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic             accept_s;
    logic             wait_s;

    assign accept_s = (state_q == S_IDLE) && start && (n_act != 7'd0) && (n_act <= MAX_C);
    assign wait_s   = (state_q == S_DRAIN_RD) && !ofifo_valid;

    // Saturating count of drain cycles spent waiting on the OFIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (accept_s) begin
            stall_q <= '0;
        end else if (wait_s && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end else begin
            stall_q <= stall_q;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: start-response table, directed tiles and random tiles
// compared cycle by cycle against a phase-level model of the instruction stream.
module tb_core_seq_ctrl;

    localparam logic [63:0] IDLE_W = 64'h0000_0001_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, acc_mode, ofifo_valid;
    logic [10:0] w_base, x_base, p_base;
    logic [6:0]  n_act;
    logic [63:0] inst;
    logic        busy, done, err;
`ifdef CORE_SEQ_PERF_EN
    logic [15:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    core_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .p_base(p_base),
        .n_act(n_act), .acc_mode(acc_mode), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .err(err)
`ifdef CORE_SEQ_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic        vs_q[$];
    int          exp_stall;
    int          sp[64];

    typedef struct {
        logic [6:0] n;
        logic       e_err;
        logic       e_done;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] xw(input logic rd, input logic [10:0] a, input logic l0w);
        logic [63:0] w;
        w = IDLE_W;
        if (rd) begin
            w[19]   = 1'b0;
            w[17:7] = a;
        end
        w[2] = l0w;
        return w;
    endfunction

    // Expected word for every cycle after the start edge, plus the ofifo_valid to drive then.
    task automatic build(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                         input int n, input logic acc);
        logic [63:0] w;
        exp_q.delete();
        vs_q.delete();
        exp_stall = 0;
        for (int k = 0; k <= 8; k++) begin
            exp_q.push_back(xw(k < 8, wb + 11'(k), k >= 1)); vs_q.push_back(1'($urandom));
        end
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(IDLE_W | 64'h9); vs_q.push_back(1'($urandom));
        end
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(IDLE_W); vs_q.push_back(1'($urandom));
        end
        for (int k = 0; k <= n; k++) begin
            exp_q.push_back(xw(k < n, xb + 11'(k), k >= 1)); vs_q.push_back(1'($urandom));
        end
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(IDLE_W | 64'hA); vs_q.push_back(1'($urandom));
        end
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < sp[i]; s++) begin
                exp_q.push_back(IDLE_W); vs_q.push_back(1'b0); exp_stall++;
            end
            w = IDLE_W; w[32] = 1'b0; w[35] = 1'b1; w[30:20] = pb + 11'(i);
            exp_q.push_back(w); vs_q.push_back(1'b1);
            w = IDLE_W; w[32] = 1'b0; w[31] = 1'b0; w[6] = 1'b1;
            w[33] = acc; w[34] = ~acc; w[30:20] = pb + 11'(i);
            exp_q.push_back(w); vs_q.push_back(1'($urandom));
        end
        exp_q.push_back(IDLE_W); vs_q.push_back(1'($urandom));
    endtask

    task automatic run(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                       input logic [6:0] n, input logic acc, input int glitch_at,
                       input int abort_at, input string tag);
        int last;
        build(wb, xb, pb, int'(n), acc);
        last = exp_q.size() - 1;
        @(negedge clk);
        start = 1'b1; w_base = wb; x_base = xb; p_base = pb; n_act = n; acc_mode = acc;
        ofifo_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        w_base = 11'($urandom); x_base = 11'($urandom); p_base = 11'($urandom);
        n_act = 7'($urandom_range(1, 64)); acc_mode = 1'($urandom);
        chk({tag, " start-edge inst"}, inst, IDLE_W);
        chk({tag, " start-edge flags"}, 64'({busy, done, err}), 64'(3'b000));
        for (int j = 0; j <= last; j++) begin
            ofifo_valid = vs_q[j];
            start = (j == glitch_at);
            if (j == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk({tag, " abort inst"}, inst, IDLE_W);
                chk({tag, " abort flags"}, 64'({busy, done, err}), 64'(3'b000));
                for (int c = 0; c < 20; c++) begin
                    ofifo_valid = 1'b1;
                    @(posedge clk); #1;
                    chk({tag, " post-abort"}, {inst[63:3], busy, done, err}, {IDLE_W[63:3], 3'b000});
                end
                return;
            end
            @(posedge clk); #1;
            chk({tag, " inst"}, inst, exp_q[j]);
            chk({tag, " flags"}, 64'({busy, done, err}), 64'({1'b1, (j == last), 1'b0}));
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, " end inst"}, inst, IDLE_W);
        chk({tag, " end flags"}, 64'({busy, done, err}), 64'(3'b000));
`ifdef CORE_SEQ_PERF_EN
        chk({tag, " stall_cycles"}, 64'(stall_cycles), 64'(exp_stall));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{7'd65,  1'b1, 1'b0};
        tbl[1] = '{7'd127, 1'b1, 1'b0};
        tbl[2] = '{7'd0,   1'b0, 1'b1};
        tbl[3] = '{7'd100, 1'b1, 1'b0};
        tbl[4] = '{7'd0,   1'b0, 1'b1};
        tbl[5] = '{7'd66,  1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; acc_mode = 1'b0; ofifo_valid = 1'b0;
        w_base = 11'd0; x_base = 11'd0; p_base = 11'd0; n_act = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset inst", inst, IDLE_W);
        chk("reset flags", 64'({busy, done, err}), 64'(3'b000));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle inst", inst, IDLE_W);

        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            start = 1'b1; n_act = tbl[t].n;
            @(posedge clk); #1;
            start = 1'b0;
            chk("table inst", inst, IDLE_W);
            chk("table flags", 64'({busy, done, err}), 64'({1'b0, tbl[t].e_done, tbl[t].e_err}));
            @(posedge clk); #1;
            chk("table next inst", inst, IDLE_W);
            chk("table next flags", 64'({busy, done, err}), 64'(3'b000));
        end

        for (int i = 0; i < 64; i++) sp[i] = 0;
        run(11'd0, 11'd8, 11'd0, 7'd4, 1'b0, -1, -1, "basic");
        for (int i = 0; i < 64; i++) sp[i] = 5;
        run(11'd0, 11'd8, 11'd0, 7'd4, 1'b1, -1, -1, "stall");
        for (int i = 0; i < 64; i++) sp[i] = 0;
        run(11'd0, 11'd8, 11'd2046, 7'd4, 1'b0, -1, -1, "pwrap");
        run(11'd2044, 11'd2045, 11'd5, 7'd64, 1'b1, -1, -1, "full");
        run(11'd0, 11'd8, 11'd0, 7'd4, 1'b0, -1, 9 + 8 + 16 + 5 + 1, "abort");
        run(11'd0, 11'd8, 11'd0, 7'd4, 1'b0, -1, -1, "after-abort");
        for (int i = 0; i < 64; i++) sp[i] = 1;
        run(11'd16, 11'd100, 11'd300, 7'd3, 1'b1, 12, -1, "glitch");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 64; i++) sp[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run(11'($urandom), 11'($urandom), 11'($urandom), 7'($urandom_range(1, 64)),
                1'($urandom), -1, -1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Instruction sequencer for one output tile of the 8x8 weight-stationary MAC core.
- Consumes a start command and drives the core's 64-bit `inst` word cycle by cycle: kernel load, activation stream, execute, then OFIFO drain into PSUM SRAM (read-modify-write).
- Sits directly upstream of the core and watches the core's `ofifo_valid` output.

Parameters:
- ROW, 8, input channels (kernel rows loaded into L0).
- COL, 8, output columns (used for load propagation wait).
- ADDR_W, 11, SRAM address width (xmem and pmem).
- MAX_ACT, 64, maximum activation vectors per tile (OFIFO depth).
- CNT_W, 16, width of the optional performance counter.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high.
- start  input  1  command strobe, sampled in IDLE only.
- w_base  input  ADDR_W  xmem address of kernel row 0.
- x_base  input  ADDR_W  xmem address of activation vector 0.
- p_base  input  ADDR_W  pmem address of output 0.
- n_act  input  7  activation vectors this tile (0..MAX_ACT).
- acc_mode  input  1  1 = accumulate onto PSUM, 0 = overwrite (passthrough).
- ofifo_valid  input  1  core OFIFO has a row available.
- inst  output  64  registered instruction word to core.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on tile completion.
- err  output  1  one-cycle pulse on rejected start.

Behaviour:
- inst field map:
  - [35] REN_pmem, [34] passthrough, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem.
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem.
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
  - [63:36] always 0; ififo_wr and ififo_rd always 0.
- Idle word: CEN_xmem = WEN_xmem = CEN_pmem = WEN_pmem = 1, all other bits 0.
- Reset: state IDLE, inst = idle word, busy = done = err = 0, all counters 0. Takes effect on the next edge from any state, aborting mid-tile with no further SRAM or FIFO strobes.
- All outputs are registered. A start sampled at edge t gives the first non-idle inst after edge t+1.
- Start handling in IDLE:
  - n_act > MAX_ACT: err pulse, stay IDLE.
  - n_act == 0: done pulse, no SRAM or FIFO activity.
  - Otherwise: latch bases, n_act and acc_mode, then go to W_L0.
  - start while busy is ignored.
- States:
  - W_L0, ROW+1 cycles, index k:
    - k < ROW: CEN_xmem = 0, WEN_xmem = 1, A_xmem = w_base + k.
    - k ≥ 1: l0_wr = 1, matching the 1-cycle SRAM read latency.
  - W_LOAD, ROW cycles: l0_rd = 1, load = 1.
  - LOAD_WAIT, ROW+COL cycles: idle word, letting the kernel settle in the array.
  - X_L0, n_act+1 cycles: same pattern as W_L0 with x_base and n_act.
  - EXEC, n_act cycles: l0_rd = 1, execute = 1.
  - DRAIN, per output i = 0..n_act-1:
    - RD sub-state waits until ofifo_valid = 1, emitting the idle word while waiting.
    - RD then issues CEN_pmem = 0, REN_pmem = 1, A_pmem = p_base + i.
    - WR next cycle: ofifo_rd = 1, CEN_pmem = 0, WEN_pmem = 0, A_pmem = p_base + i, acc = acc_mode, passthrough = ~acc_mode.
    - Minimum 2 cycles per output.
  - DONE, 1 cycle: done = 1, idle word; then IDLE.
- Address arithmetic is modulo 2^ADDR_W; base + index wraps silently.
- No timeout: DRAIN stalls indefinitely while ofifo_valid = 0; busy stays high.

Optional Feature:
- Macro: CORE_SEQ_PERF_EN.
- Enabled:
  - Adds output `stall_cycles` [CNT_W-1:0], counting DRAIN cycles spent waiting on ofifo_valid = 0.
  - Cleared on an accepted start and by reset; saturates at all-ones; holds its value after done.
- Disabled: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then start with w_base = 0, x_base = 8, p_base = 0, n_act = 4, acc_mode = 0, ofifo_valid = 1 -> exactly:
  - A_xmem 0..7, then 8..11.
  - 8 load cycles, 16 wait cycles, 4 execute cycles.
  - pmem writes at addresses 0..3 with passthrough = 1.
  - done pulses once; busy high throughout.
- Same run with acc_mode = 1 and ofifo_valid held low 5 cycles before each output -> each RD delayed 5 cycles, acc = 1 on writes; `stall_cycles` = 20 when the perf macro is enabled.
- start with n_act = 65 -> err pulse, busy stays 0, inst stays idle word. start with n_act = 0 -> done pulse next cycle, no strobes.
- p_base = 2046, n_act = 4 -> write addresses 2046, 2047, 0, 1.
- Assert reset during EXEC cycle 2 -> next cycle inst = idle word, busy = 0, no done. A subsequent start runs normally.
- Pulse start again during W_LOAD -> ignored; the tile completes with a single done pulse.
